// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler.
// Cue ids (index 0 = highest priority), FSM state encoding, the cue ROM entry
// layout {last, dur, note}, and small helpers shared by the scheduler and its ROM.
package sfx_pkg;

  localparam int NUM_CUES = 5;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 8;
  localparam int STEP_W   = 4;
  localparam int CUE_W    = 3;

  localparam logic [CUE_W-1:0] CUE_WIN   = 3'd0;
  localparam logic [CUE_W-1:0] CUE_LOSE  = 3'd1;
  localparam logic [CUE_W-1:0] CUE_SCORE = 3'd2;
  localparam logic [CUE_W-1:0] CUE_LIFE  = 3'd3;
  localparam logic [CUE_W-1:0] CUE_CLICK = 3'd4;
  localparam logic [CUE_W-1:0] CUE_NONE  = 3'd7;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef struct packed {
    logic              last;
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } rom_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  function automatic rom_entry_t mk_entry(input logic l, input logic [DUR_W-1:0] d,
                                          input logic [NOTE_W-1:0] n);
    rom_entry_t e;
    e.last = l;
    e.dur  = d;
    e.note = n;
    return e;
  endfunction

  // Index of the lowest set bit (highest priority), CUE_NONE when empty.
  function automatic logic [CUE_W-1:0] lowest_set(input logic [NUM_CUES-1:0] v);
    logic [CUE_W-1:0] r;
    r = CUE_NONE;
    for (int i = NUM_CUES - 1; i >= 0; i--) begin
      if (v[i]) r = CUE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Bus between the game logic (master) and the sound-effect scheduler (slave).
//  tick       note-time strobe        enabled    sound enable
//  req        per-cue event levels    note       note code to tone generator
//  busy       cue in LOAD/PLAY        active_cue playing cue id, 7 when idle
//  cue_done   last-note expiry pulse  cue_abort  preemption pulse
interface sfx_scheduler_if;
  import sfx_pkg::*;

  logic                tick;
  logic                enabled;
  logic [NUM_CUES-1:0] req;
  logic [NOTE_W-1:0]   note;
  logic                busy;
  logic [CUE_W-1:0]    active_cue;
  logic                cue_done;
  logic                cue_abort;

  modport master (output tick, enabled, req,
                  input  note, busy, active_cue, cue_done, cue_abort);
  modport slave  (input  tick, enabled, req,
                  output note, busy, active_cue, cue_done, cue_abort);
endinterface

// File: rtl/sfx_cue_rom.sv
// Registered cue table lookup, address {cue_id, step}, one clock of latency.
//  clk, reset  clock and asynchronous active-high reset
//  cue_id      cue being sequenced
//  step        note index within the cue
//  entry       {last, dur, note} for the address presented on the previous clock
// TEST_ROM swaps the click table for a short one containing a zero-duration note.
module sfx_cue_rom
  import sfx_pkg::*;
#(
  parameter bit TEST_ROM = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CUE_W-1:0]  cue_id,
  input  logic [STEP_W-1:0] step,
  output rom_entry_t        entry
);

  function automatic rom_entry_t lookup(input logic [CUE_W-1:0] c, input logic [STEP_W-1:0] s);
    rom_entry_t e;
    e = mk_entry(1'b1, 8'd1, NOTE_REST);
    case (c)
      CUE_WIN: case (s)
        4'd0:  e = mk_entry(1'b0, 8'd8, 6'd15);
        4'd1:  e = mk_entry(1'b0, 8'd8, 6'd17);
        4'd2:  e = mk_entry(1'b0, 8'd8, 6'd19);
        4'd3:  e = mk_entry(1'b0, 8'd8, 6'd20);
        4'd4:  e = mk_entry(1'b0, 8'd8, 6'd22);
        4'd5:  e = mk_entry(1'b0, 8'd8, 6'd24);
        4'd6:  e = mk_entry(1'b0, 8'd8, 6'd26);
        4'd7:  e = mk_entry(1'b0, 8'd8, 6'd27);
        4'd8:  e = mk_entry(1'b0, 8'd8, 6'd29);
        4'd9:  e = mk_entry(1'b0, 8'd8, 6'd31);
        4'd10: e = mk_entry(1'b0, 8'd8, 6'd34);
        4'd11: e = mk_entry(1'b1, 8'd8, 6'd39);
        default: ;
      endcase
      CUE_LOSE: case (s)
        4'd0: e = mk_entry(1'b0, 8'd20, 6'd24);
        4'd1: e = mk_entry(1'b0, 8'd20, 6'd22);
        4'd2: e = mk_entry(1'b0, 8'd20, 6'd20);
        4'd3: e = mk_entry(1'b0, 8'd20, 6'd19);
        4'd4: e = mk_entry(1'b0, 8'd20, 6'd17);
        4'd5: e = mk_entry(1'b1, 8'd20, 6'd15);
        default: ;
      endcase
      CUE_SCORE: case (s)
        4'd0: e = mk_entry(1'b0, 8'd30, 6'd15);
        4'd1: e = mk_entry(1'b0, 8'd30, 6'd22);
        4'd2: e = mk_entry(1'b0, 8'd30, 6'd19);
        4'd3: e = mk_entry(1'b1, 8'd30, 6'd25);
        default: ;
      endcase
      CUE_LIFE: case (s)
        4'd0: e = mk_entry(1'b0, 8'd15, 6'd36);
        4'd1: e = mk_entry(1'b0, 8'd15, 6'd34);
        4'd2: e = mk_entry(1'b0, 8'd15, 6'd31);
        4'd3: e = mk_entry(1'b0, 8'd15, 6'd29);
        4'd4: e = mk_entry(1'b0, 8'd15, 6'd27);
        4'd5: e = mk_entry(1'b1, 8'd15, 6'd24);
        default: ;
      endcase
      CUE_CLICK: begin
        if (TEST_ROM) begin
          case (s)
            4'd0: e = mk_entry(1'b0, 8'd0, 6'd15);
            4'd1: e = mk_entry(1'b1, 8'd2, 6'd16);
            default: ;
          endcase
        end else begin
          case (s)
            4'd0: e = mk_entry(1'b0, 8'd30, 6'd15);
            4'd1: e = mk_entry(1'b0, 8'd20, 6'd16);
            4'd2: e = mk_entry(1'b0, 8'd20, 6'd17);
            4'd3: e = mk_entry(1'b1, 8'd30, 6'd19);
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  rom_entry_t entry_d;

  // The final step index is always terminal so the step counter can never wrap.
  always_comb begin
    entry_d = lookup(cue_id, step);
    if (&step) entry_d.last = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry <= '0;
    else       entry <= entry_d;
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates cue requests onto one buzzer and sequences
// the granted cue's notes from the cue ROM.
//  clk, reset  clock and asynchronous active-high reset
//  bus         slave side of sfx_scheduler_if (tick, enabled, req in;
//              note, busy, active_cue, cue_done, cue_abort out)
// Cues in PREEMPT_MASK abort a lower-priority active cue on the next tick; all
// other requests wait in a one-flag-per-cue pending register.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter logic [NUM_CUES-1:0] PREEMPT_MASK = 5'b00011,
  parameter bit                  TEST_ROM     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  sfx_scheduler_if.slave  bus
);

  state_e              state_q, state_d;
  logic [NUM_CUES-1:0] prev_req_q;
  logic [NUM_CUES-1:0] pending_q, pending_d;
  logic [NUM_CUES-1:0] req_rise, grant;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CUE_W-1:0]    cue_q, cue_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic [CUE_W-1:0]    winner, pre_winner;
  logic                preempt;
  rom_entry_t          rom_q;

  // The ROM is addressed with the next cue/step so its registered output is
  // valid for the current cue/step while the FSM sits in LOAD.
  sfx_cue_rom #(.TEST_ROM(TEST_ROM)) u_rom (
    .clk    (clk),
    .reset  (reset),
    .cue_id (cue_d),
    .step   (step_d),
    .entry  (rom_q)
  );

  assign req_rise   = bus.req & ~prev_req_q;
  assign winner     = lowest_set(pending_q);
  assign pre_winner = lowest_set(pending_q & PREEMPT_MASK);
  assign preempt    = (pre_winner != CUE_NONE) && (pre_winner < cue_q);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cue_d     = cue_q;
    note_d    = note_q;
    dur_d     = dur_q;
    last_d    = last_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    grant     = '0;
    pending_d = '0;
    if (!bus.enabled) begin
      // Silent flush: no done/abort pulse, queued requests discarded.
      state_d = ST_IDLE;
      cue_d   = CUE_NONE;
      step_d  = '0;
      note_d  = NOTE_REST;
      dur_d   = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.tick && |pending_q) begin
            state_d = ST_LOAD;
            cue_d   = winner;
            step_d  = '0;
            grant   = NUM_CUES'(1) << winner;
          end
        end
        ST_LOAD: begin
          if (bus.tick && preempt) begin
            abort_d = 1'b1;
            cue_d   = pre_winner;
            step_d  = '0;
            grant   = NUM_CUES'(1) << pre_winner;
          end else begin
            state_d = ST_PLAY;
            note_d  = rom_q.note;
            dur_d   = (rom_q.dur == '0) ? DUR_W'(1) : rom_q.dur;
            last_d  = rom_q.last;
          end
        end
        ST_PLAY: begin
          if (bus.tick) begin
            // Final-note expiry wins over a preempt on the same tick.
            if (dur_q == DUR_W'(1) && last_q) begin
              state_d = ST_IDLE;
              note_d  = NOTE_REST;
              done_d  = 1'b1;
              cue_d   = CUE_NONE;
              step_d  = '0;
            end else if (preempt) begin
              state_d = ST_LOAD;
              abort_d = 1'b1;
              cue_d   = pre_winner;
              step_d  = '0;
              grant   = NUM_CUES'(1) << pre_winner;
            end else if (dur_q == DUR_W'(1)) begin
              state_d = ST_LOAD;
              step_d  = step_q + STEP_W'(1);
            end else begin
              dur_d = dur_q - DUR_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A fresh edge in the grant cycle keeps its pending bit set.
      pending_d = (pending_q & ~grant) | req_rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_req_q <= '1;
      pending_q  <= '0;
      step_q     <= '0;
      cue_q      <= CUE_NONE;
      note_q     <= NOTE_REST;
      dur_q      <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_req_q <= bus.req;
      pending_q  <= pending_d;
      step_q     <= step_d;
      cue_q      <= cue_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      last_q     <= last_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.note       = note_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.active_cue = cue_q;
  assign bus.cue_done   = done_q;
  assign bus.cue_abort  = abort_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler: one task per scenario, note sequences
// captured as run-length (note, ticks) pairs sampled at each tick.
module tb_sfx_scheduler;
  import sfx_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                tick = 1'b0;
  logic                enabled = 1'b1;
  logic [NUM_CUES-1:0] req_m = '0;
  logic [NUM_CUES-1:0] req_t = '0;
  bit                  use_t = 1'b0;

  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int dones = 0;
  int aborts = 0;
  bit started = 1'b0;
  int run_note[$];
  int run_len[$];

  sfx_scheduler_if bm();
  sfx_scheduler_if bt();

  assign bm.tick = tick;
  assign bm.enabled = enabled;
  assign bm.req = req_m;
  assign bt.tick = tick;
  assign bt.enabled = enabled;
  assign bt.req = req_t;

  sfx_scheduler #(.TEST_ROM(1'b0)) dut   (.clk(clk), .reset(reset), .bus(bm.slave));
  sfx_scheduler #(.TEST_ROM(1'b1)) dut_t (.clk(clk), .reset(reset), .bus(bt.slave));

  always #5 clk = ~clk;

  logic [NOTE_W-1:0] note_s;
  logic [CUE_W-1:0]  cue_s;
  logic              busy_s, done_s, abort_s;
  assign note_s  = use_t ? bt.note       : bm.note;
  assign cue_s   = use_t ? bt.active_cue : bm.active_cue;
  assign busy_s  = use_t ? bt.busy       : bm.busy;
  assign done_s  = use_t ? bt.cue_done   : bm.cue_done;
  assign abort_s = use_t ? bt.cue_abort  : bm.cue_abort;

  task automatic cyc1();
    @(posedge clk);
    #1;
    cnt++;
    tick = (cnt % 4 == 0);
  endtask

  task automatic clear_rec();
    run_note.delete();
    run_len.delete();
    dones = 0;
    aborts = 0;
    started = 1'b0;
  endtask

  task automatic record(input int n);
    if (run_note.size() == 0 || run_note[run_note.size()-1] != n) begin
      run_note.push_back(n);
      run_len.push_back(1);
    end else begin
      run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc1();
      if (done_s) dones++;
      if (abort_s) aborts++;
      if (busy_s) started = 1'b1;
      if (tick && started) record(int'(note_s));
    end
  endtask

  task automatic test_reset();
    clear_rec();
    reset = 1'b1;
    req_m = 5'b00010;
    run(3);
    checks++; if (note_s !== 6'd0) begin failures++; $display("FAIL reset_note got=%0d want=0", note_s); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy_s); end
    checks++; if (cue_s !== 3'd7) begin failures++; $display("FAIL reset_cue got=%0d want=7", cue_s); end
    checks++; if (done_s !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done_s); end
    checks++; if (abort_s !== 1'b0) begin failures++; $display("FAIL reset_abort got=%0b want=0", abort_s); end
    reset = 1'b0;
    run(80);
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL reset_level_no_start got=%0b want=0", busy_s); end
    checks++; if (dones !== 0) begin failures++; $display("FAIL reset_level_dones got=%0d want=0", dones); end
    req_m = '0;
    run(4);
  endtask

  task automatic test_click();
    int exp_n[5] = '{15, 16, 17, 19, 0};
    int exp_l[4] = '{30, 20, 20, 30};
    clear_rec();
    req_m = 5'b10000;
    run(1);
    req_m = '0;
    run(39);
    checks++; if (cue_s !== 3'd4) begin failures++; $display("FAIL click_active_cue got=%0d want=4", cue_s); end
    run(400);
    checks++; if (run_note.size() !== 5) begin failures++; $display("FAIL click_runs got=%0d want=5", run_note.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (run_note[i] !== exp_n[i]) begin failures++; $display("FAIL click_note%0d got=%0d want=%0d", i, run_note[i], exp_n[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (run_len[i] !== exp_l[i]) begin failures++; $display("FAIL click_len%0d got=%0d want=%0d", i, run_len[i], exp_l[i]); end
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL click_dones got=%0d want=1", dones); end
    checks++; if (aborts !== 0) begin failures++; $display("FAIL click_aborts got=%0d want=0", aborts); end
    checks++; if (cue_s !== 3'd7) begin failures++; $display("FAIL click_idle_cue got=%0d want=7", cue_s); end
    checks++; if (note_s !== 6'd0) begin failures++; $display("FAIL click_idle_note got=%0d want=0", note_s); end
  endtask

  task automatic test_queue();
    int exp_n[10] = '{15, 22, 19, 25, 0, 15, 16, 17, 19, 0};
    int exp_l[10] = '{30, 30, 30, 30, 0, 30, 20, 20, 30, 0};
    clear_rec();
    req_m = 5'b10100;
    run(1);
    req_m = '0;
    run(920);
    checks++; if (run_note.size() !== 10) begin failures++; $display("FAIL queue_runs got=%0d want=10", run_note.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (run_note[i] !== exp_n[i]) begin failures++; $display("FAIL queue_note%0d got=%0d want=%0d", i, run_note[i], exp_n[i]); end
      if (i != 4 && i != 9) begin
        checks++;
        if (run_len[i] !== exp_l[i]) begin failures++; $display("FAIL queue_len%0d got=%0d want=%0d", i, run_len[i], exp_l[i]); end
      end
    end
    checks++; if (run_len[4] < 1) begin failures++; $display("FAIL queue_rest got=%0d want>=1", run_len[4]); end
    checks++; if (dones !== 2) begin failures++; $display("FAIL queue_dones got=%0d want=2", dones); end
  endtask

  task automatic test_preempt();
    bit found = 1'b0;
    bit seen = 1'b0;
    clear_rec();
    req_m = 5'b10000;
    run(1);
    req_m = '0;
    for (int i = 0; i < 400; i++) begin
      run(1);
      if (note_s == 6'd16) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL preempt_reach_note2 got=%0b want=1", found); end
    run(8);
    req_m = 5'b00001;
    run(1);
    req_m = '0;
    for (int i = 0; i < 12; i++) begin
      run(1);
      if (abort_s) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL preempt_abort got=%0b want=1", seen); end
    checks++; if (cue_s !== 3'd0) begin failures++; $display("FAIL preempt_cue got=%0d want=0", cue_s); end
    run(1);
    checks++; if (note_s !== 6'd15) begin failures++; $display("FAIL preempt_note got=%0d want=15", note_s); end
    run(450);
    checks++; if (dones !== 1) begin failures++; $display("FAIL preempt_dones got=%0d want=1", dones); end
    checks++; if (aborts !== 1) begin failures++; $display("FAIL preempt_aborts got=%0d want=1", aborts); end
    run(40);
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL preempt_no_resume got=%0b want=0", busy_s); end
  endtask

  task automatic test_non_preempt();
    int exp_n[4] = '{15, 22, 19, 25};
    clear_rec();
    req_m = 5'b00100;
    run(1);
    req_m = '0;
    run(40);
    req_m = 5'b01000;
    run(1);
    req_m = '0;
    run(880);
    checks++; if (run_note.size() < 6) begin failures++; $display("FAIL nonpre_runs got=%0d want>=6", run_note.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (run_note[i] !== exp_n[i]) begin failures++; $display("FAIL nonpre_note%0d got=%0d want=%0d", i, run_note[i], exp_n[i]); end
    end
    checks++; if (run_note[4] !== 0) begin failures++; $display("FAIL nonpre_rest_note got=%0d want=0", run_note[4]); end
    checks++; if (run_note[5] !== 36) begin failures++; $display("FAIL nonpre_life_note got=%0d want=36", run_note[5]); end
    checks++; if (run_len[5] !== 15) begin failures++; $display("FAIL nonpre_life_len got=%0d want=15", run_len[5]); end
    checks++; if (aborts !== 0) begin failures++; $display("FAIL nonpre_aborts got=%0d want=0", aborts); end
    checks++; if (dones !== 2) begin failures++; $display("FAIL nonpre_dones got=%0d want=2", dones); end
  endtask

  task automatic test_disable_reset();
    clear_rec();
    req_m = 5'b00001;
    run(1);
    req_m = '0;
    run(40);
    req_m = 5'b10000;
    run(1);
    req_m = '0;
    run(8);
    enabled = 1'b0;
    run(1);
    checks++; if (note_s !== 6'd0) begin failures++; $display("FAIL dis_note got=%0d want=0", note_s); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL dis_busy got=%0b want=0", busy_s); end
    checks++; if (cue_s !== 3'd7) begin failures++; $display("FAIL dis_cue got=%0d want=7", cue_s); end
    req_m = 5'b10000;
    run(8);
    enabled = 1'b1;
    run(60);
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL dis_reenable_busy got=%0b want=0", busy_s); end
    checks++; if (dones !== 0) begin failures++; $display("FAIL dis_dones got=%0d want=0", dones); end
    checks++; if (aborts !== 0) begin failures++; $display("FAIL dis_aborts got=%0d want=0", aborts); end
    req_m = '0;
    run(4);
    req_m = 5'b00100;
    run(1);
    req_m = '0;
    run(30);
    checks++; if (busy_s !== 1'b1) begin failures++; $display("FAIL rst_precond_busy got=%0b want=1", busy_s); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (note_s !== 6'd0) begin failures++; $display("FAIL rst_mid_note got=%0d want=0", note_s); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b want=0", busy_s); end
    checks++; if (cue_s !== 3'd7) begin failures++; $display("FAIL rst_mid_cue got=%0d want=7", cue_s); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(20);
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%0b want=0", busy_s); end
  endtask

  task automatic test_coalesce();
    clear_rec();
    req_m = 5'b00100;
    run(1);
    req_m = '0;
    run(20);
    for (int k = 0; k < 3; k++) begin
      req_m = 5'b10000;
      run(1);
      req_m = '0;
      run(9);
    end
    run(900);
    checks++; if (run_note.size() !== 10) begin failures++; $display("FAIL coal_runs got=%0d want=10", run_note.size()); end
    checks++; if (run_note[5] !== 15) begin failures++; $display("FAIL coal_click_note0 got=%0d want=15", run_note[5]); end
    checks++; if (run_note[8] !== 19) begin failures++; $display("FAIL coal_click_note3 got=%0d want=19", run_note[8]); end
    checks++; if (run_note[9] !== 0) begin failures++; $display("FAIL coal_tail got=%0d want=0", run_note[9]); end
    checks++; if (dones !== 2) begin failures++; $display("FAIL coal_dones got=%0d want=2", dones); end
  endtask

  task automatic test_zero_dur();
    clear_rec();
    use_t = 1'b1;
    req_t = 5'b10000;
    run(1);
    req_t = '0;
    run(60);
    checks++; if (run_note.size() !== 3) begin failures++; $display("FAIL zdur_runs got=%0d want=3", run_note.size()); end
    checks++; if (run_note[0] !== 15) begin failures++; $display("FAIL zdur_note0 got=%0d want=15", run_note[0]); end
    checks++; if (run_len[0] !== 1) begin failures++; $display("FAIL zdur_len0 got=%0d want=1", run_len[0]); end
    checks++; if (run_note[1] !== 16) begin failures++; $display("FAIL zdur_note1 got=%0d want=16", run_note[1]); end
    checks++; if (run_len[1] !== 2) begin failures++; $display("FAIL zdur_len1 got=%0d want=2", run_len[1]); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL zdur_dones got=%0d want=1", dones); end
    use_t = 1'b0;
  endtask

  initial begin
    test_reset();
    test_click();
    test_queue();
    test_preempt();
    test_non_preempt();
    test_disable_reset();
    test_coalesce();
    test_zero_dur();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
